// File: rtl/vga_timing_gen_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants and types for the 640x480@60 raster timing generator.
// Holds the default timing (used as parameter defaults by vga_timing_gen),
// the derived totals and sync window bounds, the coordinate width, and the
// flag decode used to turn a counter position into sync/active outputs.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int COORD_W     = 10;
  localparam int FRAME_CNT_W = 8;

  // Default 640x480@60 timing, in pixels / lines.
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef logic [COORD_W-1:0]     coord_t;
  typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
    logic frame_start;
  } vid_flags_t;

  localparam vid_flags_t VID_FLAGS_RESET = '{
    hsync:       1'b1,
    vsync:       1'b1,
    active:      1'b0,
    frame_start: 1'b0
  };

  // True when lo <= c < hi.
  function automatic logic in_span(coord_t c, int lo, int hi);
    return (int'(c) >= lo) && (int'(c) < hi);
  endfunction

  // Output flags belonging to counter position (h, v). Syncs are active-low.
  function automatic vid_flags_t decode_flags(coord_t h, coord_t v,
                                              int h_act, int v_act,
                                              int hs_start, int hs_end,
                                              int vs_start, int vs_end);
    vid_flags_t f;
    f.hsync       = ~in_span(h, hs_start, hs_end);
    f.vsync       = ~in_span(v, vs_start, vs_end);
    f.active      = (int'(h) < h_act) && (int'(v) < v_act);
    f.frame_start = (h == '0) && (v == '0);
    return f;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Video timing bundle from the raster generator to its consumers (colour-bar
// pattern stage and VGA pin drivers).
//   pix_tick    : one-clk pulse per pixel period
//   x, y        : raw horizontal / vertical position (not clamped in blanking)
//   hsync/vsync : active-low syncs
//   active      : visible region, consumers must gate colour with it
//   frame_start : high for the pixel at (0,0)
//   frame_cnt   : frame counter, only with VGA_FRAME_CNT_EN defined
// Modports: master = generator side, slave = consumer side.
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic   pix_tick;
  coord_t x;
  coord_t y;
  logic   hsync;
  logic   vsync;
  logic   active;
  logic   frame_start;
`ifdef VGA_FRAME_CNT_EN
  frame_cnt_t frame_cnt;

  modport master (output pix_tick, x, y, hsync, vsync, active, frame_start, frame_cnt);
  modport slave  (input  pix_tick, x, y, hsync, vsync, active, frame_start, frame_cnt);
`else
  modport master (output pix_tick, x, y, hsync, vsync, active, frame_start);
  modport slave  (input  pix_tick, x, y, hsync, vsync, active, frame_start);
`endif

endinterface

// File: rtl/vga_timing_gen_pix_tick.sv
// ---------------------------------------------------------------------------
// pix_tick_gen
// Pixel-rate enable. div_cnt counts 0..CLK_DIV-1 and wraps; pix_tick is high
// in the cycle where div_cnt is at its last value. With CLK_DIV=1 the counter
// never moves and pix_tick is high every cycle outside reset.
// Ports:
//   clk      : system clock
//   reset    : synchronous, active-high
//   pix_tick : one-clk pulse per pixel period (combinational, 0 in reset)
// ---------------------------------------------------------------------------
module pix_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic pix_tick
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // Gated with reset so the tick reads 0 while reset is held, which matters
  // for CLK_DIV=1 where the compare is otherwise always true.
  assign pix_tick = ~reset & (div_cnt_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Raster timing generator, 640x480@60 by default (50 MHz clk, CLK_DIV=2).
// A pixel-rate enable from pix_tick_gen advances the horizontal counter;
// line end advances the vertical counter. Every output except pix_tick is a
// register loaded on pix_tick with the decode of the counter position being
// left, so each output value lasts exactly one pixel period and trails the
// counters by one pixel.
// Ports:
//   clk   : system clock (only clock)
//   reset : synchronous, active-high; returns all state to reset values
//   vid   : vga_timing_gen_if.master (pix_tick, x, y, hsync, vsync, active,
//           frame_start, and frame_cnt when enabled)
// Build option: define VGA_FRAME_CNT_EN to add the 8-bit frame counter, which
// increments on the tick where the outputs become (0,0) and wraps 255->0.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vid
);
  import vga_timing_pkg::*;

  localparam int LINE_TICKS  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START    = H_ACTIVE + H_FP;
  localparam int HS_END      = HS_START + H_SYNC;
  localparam int VS_START    = V_ACTIVE + V_FP;
  localparam int VS_END      = VS_START + V_SYNC;

  localparam coord_t H_LAST = coord_t'(LINE_TICKS - 1);
  localparam coord_t V_LAST = coord_t'(FRAME_LINES - 1);

  logic pix_tick;

  pix_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .pix_tick (pix_tick)
  );

  coord_t     h_cnt_q, h_cnt_d;
  coord_t     v_cnt_q, v_cnt_d;
  coord_t     x_q, x_d;
  coord_t     y_q, y_d;
  vid_flags_t flags_q, flags_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    flags_d = flags_q;

    if (pix_tick) begin
      // Outputs take the position being left, then the counters move on.
      x_d     = h_cnt_q;
      y_d     = v_cnt_q;
      flags_d = decode_flags(h_cnt_q, v_cnt_q, H_ACTIVE, V_ACTIVE,
                             HS_START, HS_END, VS_START, VS_END);

      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + coord_t'(1);
        end
      end else begin
        h_cnt_d = h_cnt_q + coord_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      flags_q <= VID_FLAGS_RESET;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      flags_q <= flags_d;
    end
  end

  assign vid.pix_tick    = pix_tick;
  assign vid.x           = x_q;
  assign vid.y           = y_q;
  assign vid.hsync       = flags_q.hsync;
  assign vid.vsync       = flags_q.vsync;
  assign vid.active      = flags_q.active;
  assign vid.frame_start = flags_q.frame_start;

`ifdef VGA_FRAME_CNT_EN
  frame_cnt_t frame_cnt_q, frame_cnt_d;

  // Counts on the same tick that loads frame_start, so the first frame after
  // reset reads 1.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (pix_tick && (h_cnt_q == '0) && (v_cnt_q == '0)) begin
      frame_cnt_d = frame_cnt_q + frame_cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign vid.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the monitor-tester video path. Divides the system clock to a pixel-rate enable and runs horizontal/vertical counters for 640x480@60. Drives the pixel coordinates consumed by the colour-bar pattern stage, and drives the sync and active-video signals consumed by the VGA output pins. Default timing assumes a 50 MHz `clk` with `CLK_DIV`=2, giving a 25 MHz pixel rate.

## Interface
- `CLK_DIV`, 2: system clocks per pixel; legal range ≥1.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BP`, 48: horizontal back porch.
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BP`, 33: vertical back porch.
- `clk` in 1: system clock. The block has one clock.
- `reset` in 1: synchronous, active-high reset.
- `pix_tick` out 1: one-`clk` pulse per pixel period.
- `x` out 10: horizontal counter, 0..H_TOTAL-1 (H_TOTAL=800).
- `y` out 10: vertical counter, 0..V_TOTAL-1 (V_TOTAL=525).
- `hsync` out 1: horizontal sync, active-low.
- `vsync` out 1: vertical sync, active-low.
- `active` out 1: high while x<H_ACTIVE and y<V_ACTIVE.
- `frame_start` out 1: high while (x,y)=(0,0).
- `frame_cnt` out 8: frame counter. Present only when `VGA_FRAME_CNT_EN` is defined.

## Operation
- Divider `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - `pix_tick`=1 in the cycle where div_cnt==CLK_DIV-1.
  - With CLK_DIV=1, `pix_tick` is constantly 1 after reset.
- On each `pix_tick`, h_cnt advances by one.
  - h_cnt==H_TOTAL-1 wraps to 0 and advances v_cnt.
  - v_cnt==V_TOTAL-1 at line end wraps to 0.
  - Both counters wrap in the same tick at (799,524).
- All outputs except `pix_tick` are registered. They are decoded from the counter value being left, and they update only on `pix_tick`. Each output value therefore holds for exactly one pixel period.
- `hsync`=0 iff H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC, i.e. x in [656,752).
- `vsync`=0 iff V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC, i.e. y in [490,492). Evaluated per pixel, so vsync edges align with x=0.
- `x`/`y` are raw counter values and are not clamped during blanking. Downstream stages must gate colour with `active`.
- Reset values:
  - div_cnt=0, h_cnt=0, v_cnt=0
  - x=0, y=0
  - hsync=1, vsync=1
  - active=0, frame_start=0, pix_tick=0
  - frame_cnt=0
- Reset asserted mid-frame returns everything to the reset values on the next `clk` edge. The frame restarts cleanly from (0,0) with no partial sync pulse carried over.

## Timing
- Reset release occurs at cycle 0.
- First `pix_tick` occurs in cycle CLK_DIV-1.
- From the edge after that tick, outputs show x=0, y=0, active=1, frame_start=1, hsync=1, vsync=1.
- Latency from counter value to outputs: one pixel period.
- Line period: 800 ticks. Frame period: 420000 ticks, i.e. 840000 `clk` at CLK_DIV=2.
- hsync low for 96 ticks per line. vsync low for 1600 ticks per frame.

## Configuration
- `VGA_FRAME_CNT_EN` defined:
  - `frame_cnt` port exists.
  - It increments by 1 on the tick where the outputs become (0,0).
  - It wraps 255→0.
  - The first frame after reset reads 1.
- Not defined: no `frame_cnt` port and no counter logic. All other behaviour is identical.

## Structure
- Package `vga_timing_pkg` holds:
  - default timing constants: H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP;
  - derived H_TOTAL/V_TOTAL and sync start/end;
  - the 10-bit coordinate width.
- One sub-module, `pix_tick_gen`, implements the parameterised divider producing `pix_tick`. Counters and decode remain in the top.

## Test plan
- Reset then run with CLK_DIV=2 → first pix_tick at cycle 1. On the next edge outputs read x=0, y=0, active=1, frame_start=1, and pix_tick repeats every 2 clk.
- One full line → active falls when x=640; hsync is 0 exactly for x=656..751; x wraps 799→0 and y increments to 1.
- One full frame → active stays 0 for y≥480; vsync is 0 for y=490..491 only; (799,524) wraps to (0,0) with frame_start=1 for one tick period; frame length is 840000 clk.
- Assert reset at (x=700, y=491), i.e. during both syncs → the next edge shows hsync=1, vsync=1, x=0, y=0, active=0, and the sequence restarts as in the first test.
- CLK_DIV=1 → pix_tick constant 1; frame length is 420000 clk; hsync/vsync windows unchanged.
- With `VGA_FRAME_CNT_EN`, run 257 frames → frame_cnt reads 1 after the first frame start, then 255, then wraps to 0 and then 1.
